max4_frame_reduce: RTL and testbench

//  Streaming front end for the 4-operand max datapath: each beat carries 4 unsigned

---
 rtl/max4_frame_reduce.sv | 179 +++++++++++++++++
 tb/tb_max4_frame_reduce.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/max4_frame_reduce.sv
// Streaming 4-operand max reducer: two compare stages pick the per-beat winner,
// then an accumulator folds the winners over a frame ending with in_last.
module max4_frame_reduce #(
    parameter int WIDTH = 128,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_c,
    input  logic [WIDTH-1:0] in_d,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [1:0]       out_lane,
    output logic [CNT_W-1:0] out_beat,
    output logic             out_sat
);

    logic en;
    logic accept;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign accept   = in_valid && en;

    logic [CNT_W-1:0] beat_cnt;
    logic             frame_sat;

    // S1 pair registers
    logic             s1_valid;
    logic [WIDTH-1:0] s1_ab_max;
    logic [WIDTH-1:0] s1_cd_max;
    logic [1:0]       s1_ab_lane;
    logic [1:0]       s1_cd_lane;
    logic [CNT_W-1:0] s1_beat;
    logic             s1_last;
    logic             s1_sat;

    // S2 beat winner
    logic             s2_valid;
    logic [WIDTH-1:0] s2_max;
    logic [1:0]       s2_lane;
    logic [CNT_W-1:0] s2_beat;
    logic             s2_last;
    logic             s2_sat;

    logic             acc_valid;
    logic [WIDTH-1:0] acc_max;
    logic [1:0]       acc_lane;
    logic [CNT_W-1:0] acc_beat;
    logic             acc_sat;

    logic             ab_hi;
    logic             cd_hi;
    logic             cd_wins;
    logic             take_s2;
    logic [WIDTH-1:0] m_max;
    logic [1:0]       m_lane;
    logic [CNT_W-1:0] m_beat;
    logic             m_sat;

    // Strict compares so the lower lane / earlier beat keeps ties
    assign ab_hi   = in_b > in_a;
    assign cd_hi   = in_d > in_c;
    assign cd_wins = s1_cd_max > s1_ab_max;

    always_comb begin
        take_s2 = !acc_valid || (s2_max > acc_max);
        m_max   = acc_max;
        m_lane  = acc_lane;
        m_beat  = acc_beat;
        if (take_s2) begin
            m_max  = s2_max;
            m_lane = s2_lane;
            m_beat = s2_beat;
        end
        m_sat = s2_sat || (acc_valid && acc_sat);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            frame_sat <= 1'b0;
        end else if (accept) begin
            if (in_last) begin
                beat_cnt  <= '0;
                frame_sat <= 1'b0;
            end else if (beat_cnt == '1) begin
                frame_sat <= 1'b1;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_ab_max  <= '0;
            s1_cd_max  <= '0;
            s1_ab_lane <= '0;
            s1_cd_lane <= '0;
            s1_beat    <= '0;
            s1_last    <= 1'b0;
            s1_sat     <= 1'b0;
        end else if (en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_ab_max  <= ab_hi ? in_b : in_a;
                s1_ab_lane <= ab_hi ? 2'd1 : 2'd0;
                s1_cd_max  <= cd_hi ? in_d : in_c;
                s1_cd_lane <= cd_hi ? 2'd3 : 2'd2;
                s1_beat    <= beat_cnt;
                s1_last    <= in_last;
                s1_sat     <= frame_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_max   <= '0;
            s2_lane  <= '0;
            s2_beat  <= '0;
            s2_last  <= 1'b0;
            s2_sat   <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_max  <= cd_wins ? s1_cd_max : s1_ab_max;
                s2_lane <= cd_wins ? s1_cd_lane : s1_ab_lane;
                s2_beat <= s1_beat;
                s2_last <= s1_last;
                s2_sat  <= s1_sat;
            end
        end
    end

    // The last beat's merge bypasses the accumulator straight into out_*
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_valid <= 1'b0;
            acc_max   <= '0;
            acc_lane  <= '0;
            acc_beat  <= '0;
            acc_sat   <= 1'b0;
            out_valid <= 1'b0;
            out_max   <= '0;
            out_lane  <= '0;
            out_beat  <= '0;
            out_sat   <= 1'b0;
        end else if (en) begin
            out_valid <= s2_valid && s2_last;
            if (s2_valid) begin
                if (s2_last) begin
                    out_max   <= m_max;
                    out_lane  <= m_lane;
                    out_beat  <= m_beat;
                    out_sat   <= m_sat;
                    acc_valid <= 1'b0;
                    acc_sat   <= 1'b0;
                end else begin
                    acc_max   <= m_max;
                    acc_lane  <= m_lane;
                    acc_beat  <= m_beat;
                    acc_sat   <= m_sat;
                    acc_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_max4_frame_reduce.sv
// Directed bench for max4_frame_reduce; a narrow beat counter exercises saturation.
module tb_max4_frame_reduce;

    localparam int W  = 128;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b, in_c, in_d;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_max;
    logic [1:0]    out_lane;
    logic [CW-1:0] out_beat;
    logic          out_sat;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [W-1:0]  q_max [$];
    logic [1:0]    q_lane[$];
    logic [CW-1:0] q_beat[$];
    logic          q_sat [$];
    int            q_cyc [$];

    max4_frame_reduce #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_lane(out_lane), .out_beat(out_beat), .out_sat(out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Each negedge with valid & ready precedes exactly one handshake edge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            q_max.push_back(out_max);
            q_lane.push_back(out_lane);
            q_beat.push_back(out_beat);
            q_sat.push_back(out_sat);
            q_cyc.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic flush();
        q_max.delete(); q_lane.delete(); q_beat.delete(); q_sat.delete(); q_cyc.delete();
    endtask

    task automatic send_beat(input logic [W-1:0] a, b, c, d, input logic last);
        bit ok = 0;
        in_valid = 1'b1;
        in_a = a; in_b = b; in_c = c; in_d = d; in_last = last;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL send_beat: in_ready stayed 0 for 60 cycles, required 1");
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_results(input int n, input int bound);
        int i = 0;
        while (q_max.size() < n && i < bound) begin
            @(posedge clk);
            i++;
        end
        #1;
        vectors++;
        if (q_max.size() < n) begin
            miscompares++;
            $display("FAIL wait_results: got %0d results, required %0d", q_max.size(), n);
        end
    endtask

    task automatic pop_result(output logic [W-1:0] m, output logic [1:0] l,
                              output logic [CW-1:0] b, output logic s);
        if (q_max.size() == 0) begin
            m = 'x; l = 'x; b = 'x; s = 1'bx;
        end else begin
            m = q_max.pop_front(); l = q_lane.pop_front();
            b = q_beat.pop_front(); s = q_sat.pop_front();
            void'(q_cyc.pop_front());
        end
    endtask

    task automatic test_reset();
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_flags: out_valid,in_ready=%b required 01", {out_valid, in_ready});
        end
        vectors++;
        if ({out_max, out_lane, out_beat, out_sat} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: max=%0d lane=%0d beat=%0d sat=%0d required all 0",
                     out_max, out_lane, out_beat, out_sat);
        end
    endtask

    task automatic test_single_beat();
        out_ready = 1'b1;
        send_beat(5, 9, 9, 1, 1'b1);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_latency_edge1: out_valid=%b required 0", out_valid);
        end
        idle(1);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL t1_latency_edge2: out_valid=%b required 0", out_valid);
        end
        idle(1);
        vectors++;
        if ({out_valid, out_max, out_lane, out_beat, out_sat} !== {1'b1, 128'd9, 2'd1, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL t1_result: valid=%b max=%0d lane=%0d beat=%0d sat=%b required 1/9/1/0/0",
                     out_valid, out_max, out_lane, out_beat, out_sat);
        end
        idle(4);
        flush();
    endtask

    task automatic test_frame();
        logic [W-1:0] m; logic [1:0] l; logic [CW-1:0] b; logic s;
        send_beat(1, 2, 3, 7, 1'b0);
        send_beat(20, 5, 6, 7, 1'b0);
        send_beat(1, 2, 20, 3, 1'b1);
        wait_results(1, 20);
        pop_result(m, l, b, s);
        vectors++;
        if ({m, l, b, s} !== {128'd20, 2'd0, 2'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL t2_frame: max=%0d lane=%0d beat=%0d sat=%b required 20/0/1/0", m, l, b, s);
        end
        idle(3);
        flush();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_m [4];
        logic [1:0]   exp_l [4];
        logic [W-1:0] m; logic [1:0] l; logic [CW-1:0] b; logic s;
        exp_m = '{128'd3, 128'd8, 128'd4, 128'd6};
        exp_l = '{2'd0, 2'd1, 2'd3, 2'd0};
        out_ready = 1'b0;
        fork
            begin
                send_beat(3, 0, 0, 0, 1'b1);
                send_beat(0, 8, 0, 0, 1'b1);
                send_beat(0, 0, 0, 4, 1'b1);
                send_beat(6, 6, 6, 6, 1'b1);
            end
            begin
                int i = 0;
                while (!out_valid && i < 20) begin
                    @(negedge clk);
                    i++;
                end
                repeat (5) begin
                    @(negedge clk);
                    vectors++;
                    if ({out_valid, in_ready, out_max, out_lane} !== {1'b1, 1'b0, 128'd3, 2'd0}) begin
                        miscompares++;
                        $display("FAIL t3_stall: valid=%b in_ready=%b max=%0d lane=%0d required 1/0/3/0",
                                 out_valid, in_ready, out_max, out_lane);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_results(4, 30);
        for (int k = 0; k < 4; k++) begin
            pop_result(m, l, b, s);
            vectors++;
            if ({m, l, b, s} !== {exp_m[k], exp_l[k], 2'd0, 1'b0}) begin
                miscompares++;
                $display("FAIL t3_order[%0d]: max=%0d lane=%0d beat=%0d sat=%b required %0d/%0d/0/0",
                         k, m, l, b, s, exp_m[k], exp_l[k]);
            end
        end
        idle(3);
        flush();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ta [8], tb_ [8], tc [8], td [8], exp_m [8];
        logic [1:0]   exp_l [8];
        logic [W-1:0] ones;
        logic [W-1:0] m; logic [1:0] l; logic [CW-1:0] b; logic s;
        int c_prev, c_now;
        ones  = '1;
        ta    = '{1, 9, 0, 5, 0,  100, 0, 0};
        tb_   = '{2, 9, 7, 0, 0,  200, 0, 1};
        tc    = '{3, 9, 7, 0, 12, 300, 0, ones};
        td    = '{4, 9, 0, 5, 11, 255, 0, ones};
        exp_m = '{4, 9, 7, 5, 12, 300, 0, ones};
        exp_l = '{2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd2};
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) send_beat(ta[k], tb_[k], tc[k], td[k], 1'b1);
        wait_results(8, 20);
        c_prev = (q_cyc.size() > 0) ? q_cyc[0] - 1 : 0;
        for (int k = 0; k < 8; k++) begin
            c_now = (q_cyc.size() > 0) ? q_cyc[0] : -1;
            pop_result(m, l, b, s);
            vectors++;
            if ({m, l, b, s} !== {exp_m[k], exp_l[k], 2'd0, 1'b0} || c_now != c_prev + 1) begin
                miscompares++;
                $display("FAIL t4_stream[%0d]: max=%0h lane=%0d beat=%0d sat=%b gap=%0d required %0h/%0d/0/0 gap=1",
                         k, m, l, b, s, c_now - c_prev, exp_m[k], exp_l[k]);
            end
            c_prev = c_now;
        end
        idle(3);
        flush();
    endtask

    task automatic test_saturation();
        logic [W-1:0] m; logic [1:0] l; logic [CW-1:0] b; logic s;
        // Exactly 2^CW beats: no saturation, winner in beat 3
        send_beat(1, 1, 1, 1, 1'b0);
        send_beat(2, 2, 2, 2, 1'b0);
        send_beat(3, 3, 3, 3, 1'b0);
        send_beat(0, 40, 0, 0, 1'b1);
        // Six beats: counter holds at 3, winner in beat 5
        send_beat(10, 1, 1, 1, 1'b0);
        send_beat(1, 10, 1, 1, 1'b0);
        send_beat(1, 1, 10, 1, 1'b0);
        send_beat(1, 1, 1, 10, 1'b0);
        send_beat(9, 9, 9, 9, 1'b0);
        send_beat(0, 0, 50, 0, 1'b1);
        // Following frame must start clean
        send_beat(1, 1, 1, 1, 1'b0);
        send_beat(2, 0, 0, 0, 1'b1);
        wait_results(3, 30);
        pop_result(m, l, b, s);
        vectors++;
        if ({m, l, b, s} !== {128'd40, 2'd1, 2'd3, 1'b0}) begin
            miscompares++;
            $display("FAIL t5_exact4: max=%0d lane=%0d beat=%0d sat=%b required 40/1/3/0", m, l, b, s);
        end
        pop_result(m, l, b, s);
        vectors++;
        if ({m, l, b, s} !== {128'd50, 2'd2, 2'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL t5_sat: max=%0d lane=%0d beat=%0d sat=%b required 50/2/3/1", m, l, b, s);
        end
        pop_result(m, l, b, s);
        vectors++;
        if ({m, l, b, s} !== {128'd2, 2'd0, 2'd1, 1'b0}) begin
            miscompares++;
            $display("FAIL t5_next: max=%0d lane=%0d beat=%0d sat=%b required 2/0/1/0", m, l, b, s);
        end
        idle(3);
        flush();
    endtask

    task automatic test_reset_midframe();
        logic [W-1:0] m; logic [1:0] l; logic [CW-1:0] b; logic s;
        send_beat(500, 600, 700, 800, 1'b0);
        send_beat(900, 100, 100, 100, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL t6_in_reset: out_valid,in_ready=%b required 01", {out_valid, in_ready});
        end
        rst_n = 1'b1;
        idle(1);
        send_beat(0, 0, 0, 0, 1'b1);
        wait_results(1, 20);
        pop_result(m, l, b, s);
        vectors++;
        if ({m, l, b, s} !== {128'd0, 2'd0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL t6_after_reset: max=%0d lane=%0d beat=%0d sat=%b required 0/0/0/0", m, l, b, s);
        end
        idle(3);
        vectors++;
        if (q_max.size() != 0) begin
            miscompares++;
            $display("FAIL t6_residue: %0d extra results, required 0", q_max.size());
        end
        flush();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        test_reset();
        test_single_beat();
        test_frame();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
